pulse_stretcher: RTL

//   Output-side counterpart of the button debouncer: turns single-cycle event pulses
//   (e.g. debounced button strobes) into human-visible fixed-width high levels on an LED/pin.

---
 rtl/pulse_stretcher_pkg.sv | 21 ++
 rtl/pulse_stretcher.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared state encoding and default 100 MHz timing for the button-debounce / pulse-stretch pair.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } ps_state_e;

  // 100 ms visible high, 50 ms low separation at 100 MHz.
  localparam int unsigned DEF_HOLD_CYCLES = 10_000_000;
  localparam int unsigned DEF_GAP_CYCLES  = 5_000_000;
  localparam int unsigned DEF_MAX_PENDING = 7;

  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed-width high levels, queueing events that
// arrive mid-pulse and replaying them in order with a guaranteed low gap between them.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned MAX_PENDING = DEF_MAX_PENDING,
  localparam int unsigned CNT_W      = cnt_width(HOLD_CYCLES, GAP_CYCLES),
  localparam int unsigned PEND_W     = $clog2(MAX_PENDING + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [CNT_W-1:0]  HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W:0]   MAX_P   = (PEND_W + 1)'(MAX_PENDING);

  ps_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              level_q, level_d;
  logic              busy_q, busy_d;

  logic              inc, gap_end, deq;
  logic [PEND_W:0]   sum, net;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;

    // Queue bookkeeping is one bit wider so a saturating add can be detected after
    // the same-cycle dequeue has been netted out.
    inc     = pulse_in && (state_q != ST_IDLE);
    gap_end = (state_q == ST_GAP) && (cnt_q == '0);
    sum     = {1'b0, pend_q} + (PEND_W + 1)'(inc);
    deq     = gap_end && (sum != '0);
    net     = sum - (PEND_W + 1)'(deq);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pulse_in) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (deq) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (net > MAX_P) begin
      pend_d = MAX_P[PEND_W-1:0];
      ovf_d  = 1'b1;
    end else begin
      pend_d = net[PEND_W-1:0];
    end

    // Abort overrides everything, including an event arriving this cycle.
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pend_d  = '0;
      ovf_d   = 1'b0;
    end

    level_d = (state_d == ST_HOLD);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule
